// File: rtl/ppu_vram_port.sv
// ppu_vram_port: CPU-side PPUADDR/PPUDATA access port onto the PPU VRAM bus.
// Holds the 14-bit VRAM address v, the PPUADDR write toggle w and the PPUDATA
// read buffer. Each PPUDATA access is sequenced by a small FSM and auto-increments v.
// Optional feature macro: PPU_PLT_RD_BYPASS_EN. When defined, palette reads
// (v >= $3F00) return VRAM data directly and refill the read buffer from the
// nametable mirror at v-$1000. Undefined (default), every read is buffered.
module ppu_vram_port (
    input  logic        i_cpu_clk,
    input  logic        i_cpu_rstn,
    input  logic [2:0]  i_reg_sel,
    input  logic        i_reg_we,
    input  logic        i_reg_re,
    input  logic [7:0]  i_reg_wdata,
    output logic [7:0]  o_reg_rdata,
    output logic        o_rd_valid,
    input  logic        i_inc32,
    input  logic        i_status_rd,
    output logic        o_busy,
    output logic [15:0] o_vram_addr,
    output logic        o_vram_we,
    output logic [7:0]  o_vram_wdata,
    input  logic [7:0]  i_vram_rdata
);

    localparam logic [2:0] SEL_PPUADDR = 3'd6;
    localparam logic [2:0] SEL_PPUDATA = 3'd7;

`ifdef PPU_PLT_RD_BYPASS_EN
    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDCAP,
        S_PLT_RD,
        S_PLT_CAP
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDCAP
    } state_t;
`endif

    state_t      state;
    logic [13:0] v;
    logic        w;
    logic [7:0]  buffer;
    logic [7:0]  rdata_q;
    logic        rd_valid_q;
    logic [13:0] v_inc;
    logic [13:0] vram_addr_sel;
    logic        addr_wr;
    logic        data_wr;
    logic        data_rd;

`ifdef PPU_PLT_RD_BYPASS_EN
    logic        plt_q;
    logic        is_plt;
    logic        plt_bypass;
`endif

    // Strobe decode; a write wins over a coincident read.
    assign addr_wr = i_reg_we && (i_reg_sel == SEL_PPUADDR);
    assign data_wr = i_reg_we && (i_reg_sel == SEL_PPUDATA);
    assign data_rd = i_reg_re && !i_reg_we && (i_reg_sel == SEL_PPUDATA);

    // Address step taken when an access retires; wraps naturally at 14 bits.
    assign v_inc  = v + (i_inc32 ? 14'd32 : 14'd1);
    assign o_busy = (state != S_IDLE);

`ifdef PPU_PLT_RD_BYPASS_EN
    assign is_plt     = (v[13:8] == 6'h3F);
    assign plt_bypass = (state == S_RDCAP) && plt_q;
    assign o_rd_valid = rd_valid_q | plt_bypass;
    assign o_reg_rdata = plt_bypass ? i_vram_rdata : rdata_q;
`else
    assign o_rd_valid  = rd_valid_q;
    assign o_reg_rdata = rdata_q;
`endif

    // VRAM address select: v normally, the nametable mirror during a buffer refill.
    // NOTE: every variable assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        vram_addr_sel = v;
`ifdef PPU_PLT_RD_BYPASS_EN
        if (state == S_PLT_RD) begin
            vram_addr_sel = v - 14'h1000;
        end
`endif
    end

    assign o_vram_addr = {2'b00, vram_addr_sel};

    // Access FSM with registered VRAM strobe, write data, and read response.
    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values, independent of statement order.
    always_ff @(posedge i_cpu_clk or negedge i_cpu_rstn) begin
        if (!i_cpu_rstn) begin
            state        <= S_IDLE;
            v            <= 14'h0000;
            w            <= 1'b0;
            buffer       <= 8'h00;
            rdata_q      <= 8'h00;
            rd_valid_q   <= 1'b0;
            o_vram_we    <= 1'b0;
            o_vram_wdata <= 8'h00;
`ifdef PPU_PLT_RD_BYPASS_EN
            plt_q        <= 1'b0;
`endif
        end else begin
            rd_valid_q <= 1'b0;

            // PPUSTATUS read clears the toggle in any state; a coincident
            // PPUADDR write below still sees the old w and leaves w at 0.
            if (i_status_rd) begin
                w <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (addr_wr) begin
                        if (!w) begin
                            v[13:8] <= i_reg_wdata[5:0];
                            w       <= !i_status_rd;
                        end else begin
                            v[7:0]  <= i_reg_wdata;
                            w       <= 1'b0;
                        end
                    end else if (data_wr) begin
                        o_vram_wdata <= i_reg_wdata;
                        o_vram_we    <= 1'b1;
                        state        <= S_WR;
                    end else if (data_rd) begin
                        state <= S_RD;
`ifdef PPU_PLT_RD_BYPASS_EN
                        plt_q <= is_plt;
                        if (!is_plt) begin
                            rd_valid_q <= 1'b1;
                            rdata_q    <= buffer;
                        end
`else
                        rd_valid_q <= 1'b1;
                        rdata_q    <= buffer;
`endif
                    end
                end

                S_WR: begin
                    o_vram_we <= 1'b0;
                    v         <= v_inc;
                    state     <= S_IDLE;
                end

                S_RD: begin
                    state <= S_RDCAP;
                end

                S_RDCAP: begin
`ifdef PPU_PLT_RD_BYPASS_EN
                    if (plt_q) begin
                        rdata_q <= i_vram_rdata;
                        state   <= S_PLT_RD;
                    end else begin
                        buffer <= i_vram_rdata;
                        v      <= v_inc;
                        state  <= S_IDLE;
                    end
`else
                    buffer <= i_vram_rdata;
                    v      <= v_inc;
                    state  <= S_IDLE;
`endif
                end

`ifdef PPU_PLT_RD_BYPASS_EN
                S_PLT_RD: begin
                    state <= S_PLT_CAP;
                end

                S_PLT_CAP: begin
                    buffer <= i_vram_rdata;
                    v      <= v_inc;
                    plt_q  <= 1'b0;
                    state  <= S_IDLE;
                end
`endif

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ppu_vram_port.sv
// tb_ppu_vram_port: directed self-checking bench for ppu_vram_port with a
// small registered-read VRAM model attached to the VRAM port.
module tb_ppu_vram_port;

    logic        clk;
    logic        rst_n;
    logic [2:0]  reg_sel;
    logic        reg_we;
    logic        reg_re;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        rd_valid;
    logic        inc32;
    logic        status_rd;
    logic        busy;
    logic [15:0] vram_addr;
    logic        vram_we;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int wr_count  = 0;
    int cnt0;

    logic [7:0] mem [0:16383];

    ppu_vram_port dut (
        .i_cpu_clk    (clk),
        .i_cpu_rstn   (rst_n),
        .i_reg_sel    (reg_sel),
        .i_reg_we     (reg_we),
        .i_reg_re     (reg_re),
        .i_reg_wdata  (reg_wdata),
        .o_reg_rdata  (reg_rdata),
        .o_rd_valid   (rd_valid),
        .i_inc32      (inc32),
        .i_status_rd  (status_rd),
        .o_busy       (busy),
        .o_vram_addr  (vram_addr),
        .o_vram_we    (vram_we),
        .o_vram_wdata (vram_wdata),
        .i_vram_rdata (vram_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // VRAM model: data appears one cycle after the address; writes are counted.
    always @(posedge clk) begin
        vram_rdata <= mem[vram_addr[13:0]];
        if (vram_we) begin
            mem[vram_addr[13:0]] = vram_wdata;
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reg_write(input logic [2:0] sel, input logic [7:0] data);
        reg_sel   = sel;
        reg_wdata = data;
        reg_we    = 1'b1;
        step();
        reg_we    = 1'b0;
    endtask

    task automatic reg_read(input logic [2:0] sel);
        reg_sel = sel;
        reg_re  = 1'b1;
        step();
        reg_re  = 1'b0;
    endtask

    task automatic set_v(input logic [7:0] hi, input logic [7:0] lo);
        reg_write(3'd6, hi);
        reg_write(3'd6, lo);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 16 && busy; i++) begin
            step();
        end
        check(tag, {15'd0, busy}, 16'h0000);
    endtask

    initial begin
        rst_n     = 1'b0;
        reg_sel   = 3'd0;
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        reg_wdata = 8'h00;
        inc32     = 1'b0;
        status_rd = 1'b0;
        mem[14'h2400] = 8'h11;
        mem[14'h2401] = 8'h22;
        mem[14'h2402] = 8'h33;
        mem[14'h3F01] = 8'h0F;
        mem[14'h2F01] = 8'h44;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_addr",  vram_addr, 16'h0000);
        check("rst_we",    {15'd0, vram_we}, 16'h0000);
        check("rst_wdata", {8'd0, vram_wdata}, 16'h0000);
        check("rst_valid", {15'd0, rd_valid}, 16'h0000);
        check("rst_rdata", {8'd0, reg_rdata}, 16'h0000);
        check("rst_busy",  {15'd0, busy}, 16'h0000);
        rst_n = 1'b1;
        step();

        // PPUADDR $21,$08 then PPUDATA $5A
        reg_write(3'd6, 8'h21);
        check("addr_hi", vram_addr, 16'h2100);
        reg_write(3'd6, 8'h08);
        check("addr_lo", vram_addr, 16'h2108);
        cnt0 = wr_count;
        reg_write(3'd7, 8'h5A);
        check("wr_we",    {15'd0, vram_we}, 16'h0001);
        check("wr_busy",  {15'd0, busy}, 16'h0001);
        check("wr_addr",  vram_addr, 16'h2108);
        check("wr_data",  {8'd0, vram_wdata}, 16'h005A);
        step();
        check("wr_we_off", {15'd0, vram_we}, 16'h0000);
        check("wr_vinc",   vram_addr, 16'h2109);
        check("wr_count",  wr_count - cnt0, 1);
        check("wr_mem",    {8'd0, mem[14'h2108]}, 16'h005A);

        // Increment by 32
        inc32 = 1'b1;
        set_v(8'h20, 8'h00);
        reg_write(3'd7, 8'hA1);
        check("i32_addr0", vram_addr, 16'h2000);
        step();
        reg_write(3'd7, 8'hA2);
        check("i32_addr1", vram_addr, 16'h2020);
        step();
        check("i32_v", vram_addr, 16'h2040);
        check("i32_mem", {8'd0, mem[14'h2020]}, 16'h00A2);
        inc32 = 1'b0;

        // Buffered reads at $2400
        set_v(8'h24, 8'h00);
        reg_read(3'd7);
        check("rd0_valid", {15'd0, rd_valid}, 16'h0001);
        check("rd0_data",  {8'd0, reg_rdata}, 16'h0000);
        check("rd0_addr",  vram_addr, 16'h2400);
        step();
        check("rd0_pulse", {15'd0, rd_valid}, 16'h0000);
        wait_idle("rd0_idle");
        check("rd0_vinc", vram_addr, 16'h2401);
        reg_read(3'd7);
        check("rd1_data", {8'd0, reg_rdata}, 16'h0011);
        wait_idle("rd1_idle");
        reg_read(3'd7);
        check("rd2_data", {8'd0, reg_rdata}, 16'h0022);
        wait_idle("rd2_idle");
        check("rd2_v", vram_addr, 16'h2403);

        // Strobe while busy is ignored; toggle untouched
        reg_write(3'd7, 8'h77);
        reg_write(3'd6, 8'h05);
        check("busy_ign", vram_addr, 16'h2404);
        set_v(8'h24, 8'h10);
        check("busy_w", vram_addr, 16'h2410);

        // Other selects are ignored
        reg_write(3'd3, 8'hFF);
        check("sel3_v",    vram_addr, 16'h2410);
        check("sel3_busy", {15'd0, busy}, 16'h0000);
        reg_read(3'd6);
        check("rd6_valid", {15'd0, rd_valid}, 16'h0000);
        check("rd6_busy",  {15'd0, busy}, 16'h0000);

        // Simultaneous write and read: write only
        reg_sel   = 3'd7;
        reg_wdata = 8'h99;
        reg_we    = 1'b1;
        reg_re    = 1'b1;
        step();
        reg_we    = 1'b0;
        reg_re    = 1'b0;
        check("wr_rd_we",    {15'd0, vram_we}, 16'h0001);
        check("wr_rd_valid", {15'd0, rd_valid}, 16'h0000);
        step();
        check("wr_rd_v", vram_addr, 16'h2411);

        // PPUSTATUS clears toggle; wrap at $3FFF
        reg_write(3'd6, 8'h3F);
        status_rd = 1'b1;
        step();
        status_rd = 1'b0;
        set_v(8'hFF, 8'hFF);
        check("st_v", vram_addr, 16'h3FFF);
        reg_write(3'd7, 8'h01);
        step();
        check("wrap1", vram_addr, 16'h0000);

        // Status read coincident with PPUADDR write
        status_rd = 1'b1;
        reg_write(3'd6, 8'h12);
        status_rd = 1'b0;
        check("co_hi", vram_addr, 16'h1200);
        reg_write(3'd6, 8'h34);
        check("co_w0", vram_addr, 16'h3400);
        reg_write(3'd6, 8'h56);
        check("co_lo", vram_addr, 16'h3456);

        // +32 wrap: $3FF0 -> $0010
        set_v(8'h3F, 8'hF0);
        inc32 = 1'b1;
        reg_write(3'd7, 8'h02);
        step();
        check("wrap32", vram_addr, 16'h0010);
        inc32 = 1'b0;

        // Palette read at $3F01
        set_v(8'h3F, 8'h01);
        reg_read(3'd7);
`ifdef PPU_PLT_RD_BYPASS_EN
        check("plt_rd_valid", {15'd0, rd_valid}, 16'h0000);
        step();
        check("plt_valid", {15'd0, rd_valid}, 16'h0001);
        check("plt_data",  {8'd0, reg_rdata}, 16'h000F);
        wait_idle("plt_idle");
        check("plt_v", vram_addr, 16'h3F02);
        set_v(8'h20, 8'h00);
        reg_read(3'd7);
        check("plt_buf", {8'd0, reg_rdata}, 16'h0044);
`else
        check("plt_valid", {15'd0, rd_valid}, 16'h0001);
        check("plt_data",  {8'd0, reg_rdata}, 16'h0033);
        wait_idle("plt_idle");
        check("plt_v", vram_addr, 16'h3F02);
        set_v(8'h20, 8'h00);
        reg_read(3'd7);
        check("plt_buf", {8'd0, reg_rdata}, 16'h000F);
`endif
        wait_idle("plt_buf_idle");

        // Reset during WR aborts the write
        set_v(8'h05, 8'h55);
        cnt0 = wr_count;
        reg_write(3'd7, 8'hEE);
        check("rw_pre_we", {15'd0, vram_we}, 16'h0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("rw_we",    {15'd0, vram_we}, 16'h0000);
        check("rw_busy",  {15'd0, busy}, 16'h0000);
        check("rw_addr",  vram_addr, 16'h0000);
        check("rw_wdata", {8'd0, vram_wdata}, 16'h0000);
        check("rw_valid", {15'd0, rd_valid}, 16'h0000);
        check("rw_rdata", {8'd0, reg_rdata}, 16'h0000);
        step();
        check("rw_count", wr_count - cnt0, 0);
        rst_n = 1'b1;
        step();

        // Reset during RD aborts the read pulse; buffer cleared
        set_v(8'h24, 8'h01);
        reg_read(3'd7);
        check("rr_pre_valid", {15'd0, rd_valid}, 16'h0001);
        rst_n = 1'b0;
        #1;
        check("rr_valid", {15'd0, rd_valid}, 16'h0000);
        check("rr_busy",  {15'd0, busy}, 16'h0000);
        step();
        rst_n = 1'b1;
        step();
        set_v(8'h24, 8'h02);
        reg_read(3'd7);
        check("rr_buf", {8'd0, reg_rdata}, 16'h0000);
        wait_idle("rr_idle");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/ppu_vram_port.md
PPU_VRAM_PORT -- requirements
Module: ppu_vram_port

Interface
REQ-001 SHALL have no parameters; widths are fixed as listed below.
REQ-002 SHALL have port i_cpu_clk  input  1  single block clock, rising edge.
REQ-003 SHALL have port i_cpu_rstn  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_reg_sel  input  3  CPU register index: 6 = PPUADDR, 7 = PPUDATA, others ignored.
REQ-005 SHALL have port i_reg_we  input  1  CPU register write strobe, one cycle.
REQ-006 SHALL have port i_reg_re  input  1  CPU register read strobe, one cycle.
REQ-007 SHALL have port i_reg_wdata  input  8  CPU write data.
REQ-008 SHALL have port o_reg_rdata  output  8  PPUDATA read result, qualified by o_rd_valid.
REQ-009 SHALL have port o_rd_valid  output  1  one-cycle pulse marking o_reg_rdata valid.
REQ-010 SHALL have port i_inc32  input  1  PPUCTRL bit2: increment 32 when 1, else 1.
REQ-011 SHALL have port i_status_rd  input  1  PPUSTATUS read pulse: clears write toggle.
REQ-012 SHALL have port o_busy  output  1  high while an access is in flight; strobes ignored.
REQ-013 SHALL have port o_vram_addr  output  16  address to VRAM config port, {2'b00, v[13:0]}.
REQ-014 SHALL have port o_vram_we  output  1  VRAM write strobe, one cycle.
REQ-015 SHALL have port o_vram_wdata  output  8  VRAM write data.
REQ-016 SHALL have port i_vram_rdata  input  8  VRAM read data, valid one cycle after address.

Function
REQ-017 SHALL hold a 14-bit address v, a toggle w, an 8-bit read buffer, and an FSM with states IDLE, WR, RD, RDCAP.
REQ-018 SHALL accept strobes only in IDLE; o_busy = (state != IDLE).
REQ-019 PPUADDR write with w=0 SHALL load v[13:8] = wdata[5:0] and set w=1; with w=1 SHALL load v[7:0] = wdata and clear w.
REQ-020 PPUDATA write SHALL latch wdata, go to WR; in WR o_vram_we=1 for exactly one cycle at address v; on leaving WR, v increments.
REQ-021 PPUDATA read SHALL go to RD with o_vram_addr=v; next cycle RDCAP captures i_vram_rdata into buffer, increments v, returns to IDLE.
REQ-022 Non-palette read (v < $3F00) SHALL return the pre-read buffer content with o_rd_valid one cycle after i_reg_re.
REQ-023 Increment SHALL be +1 or +32 per i_inc32 sampled at increment time, modulo 2^14 ($3FFF+1 = $0000, $3FF0+32 = $0010).
REQ-024 i_status_rd SHALL clear w in any state; coincident with a PPUADDR write, the write uses the old w and w ends at 0.
REQ-025 Simultaneous i_reg_we and i_reg_re SHALL process the write only.
REQ-026 i_reg_sel values other than 6/7 SHALL cause no state change.

Reset
REQ-027 Reset SHALL set v=0, w=0, buffer=$00, state=IDLE, o_vram_we=0, o_rd_valid=0, o_reg_rdata=$00, o_vram_wdata=$00, o_busy=0.
REQ-028 Reset asserted in WR or RD SHALL abort with no VRAM write and no o_rd_valid pulse.

Configuration
REQ-029 Macro PPU_PLT_RD_BYPASS_EN: when defined, reads with v >= $3F00 SHALL return i_vram_rdata directly with o_rd_valid in RDCAP (two cycles after i_reg_re), buffer loaded from address v-$1000 via an extra read cycle before IDLE.
REQ-030 When PPU_PLT_RD_BYPASS_EN is undefined, palette reads SHALL behave exactly as REQ-022 (buffered).

Verification
REQ-031 Write PPUADDR $21,$08, PPUDATA $5A -> o_vram_we one cycle, addr $2108, data $5A; v becomes $2109.
REQ-032 i_inc32=1, v=$2000, two PPUDATA writes -> VRAM writes at $2000 and $2020; v=$2040.
REQ-033 VRAM $2400 holds $11, $2401 holds $22; set v=$2400, three reads -> o_reg_rdata $00, $11, $22.
REQ-034 PPUADDR $3F, i_status_rd, PPUADDR $FF, $FF -> v=$3FFF; PPUDATA write -> v wraps to $0000.
REQ-035 With macro defined, VRAM $3F01=$0F, $2F01=$44; read at $3F01 -> o_reg_rdata $0F two cycles later, buffer $44.
REQ-036 Assert reset during WR -> no o_vram_we pulse, all outputs at REQ-027 values.
